// File: rtl/regfile_mp.sv
// regfile_mp: dual-pipe register file with six combinational read ports,
// two write ports, a post-reset zeroing sweep, optional same-cycle
// write-to-read forwarding and saturating collision accounting.
module regfile_mp #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 7,
  parameter int WR_PRIO = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra_ep_address,
  input  logic [ADDR_W-1:0] rb_ep_address,
  input  logic [ADDR_W-1:0] rc_ep_address,
  input  logic [ADDR_W-1:0] ra_op_address,
  input  logic [ADDR_W-1:0] rb_op_address,
  input  logic [ADDR_W-1:0] rc_op_address,
  input  logic              wrt_en_ep,
  input  logic [ADDR_W-1:0] rt_ep_address,
  input  logic [DATA_W-1:0] rt_value_ep,
  input  logic              wrt_en_op,
  input  logic [ADDR_W-1:0] rt_op_address,
  input  logic [DATA_W-1:0] rt_value_op,
  output logic [DATA_W-1:0] ra_ep_value,
  output logic [DATA_W-1:0] rb_ep_value,
  output logic [DATA_W-1:0] rc_ep_value,
  output logic [DATA_W-1:0] ra_op_value,
  output logic [DATA_W-1:0] rb_op_value,
  output logic [DATA_W-1:0] rc_op_value,
  output logic              init_done,
  output logic              wr_collision,
  output logic [15:0]       collision_count
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit OP_WINS = (WR_PRIO != 0);
  localparam bit FWD_EN  = (BYPASS != 0);
  localparam int NPORT   = 6;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                ready;
  logic                collide;
  logic                wr_ep_go;
  logic                wr_op_go;
  logic [ADDR_W-1:0]   rd_addr [NPORT];
  logic [DATA_W-1:0]   rd_val  [NPORT];

  assign ready   = (state == READY);
  assign collide = ready && wrt_en_ep && wrt_en_op && (rt_ep_address == rt_op_address);
  // On a collision the losing port is suppressed, so the array and the
  // forwarding path both see exactly one writer for that address.
  assign wr_ep_go = ready && wrt_en_ep && !(collide && OP_WINS);
  assign wr_op_go = ready && wrt_en_op && !(collide && !OP_WINS);

  // State register: reset always restarts the clear sweep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Next state: leave CLEAR once the last entry has been zeroed.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && ptr == {ADDR_W{1'b1}}) state_nxt = READY;
  end

  // Output decode: the file is usable only in READY.
  always_comb begin
    init_done = (state == READY);
  end

  // Clear pointer walks every entry once per sweep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               ptr <= '0;
    else if (state == CLEAR) ptr <= ptr + 1'b1;
  end

  // Storage: zero fill during the sweep, pipe writes once ready.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else begin
      if (wr_ep_go) mem[rt_ep_address] <= rt_value_ep;
      if (wr_op_go) mem[rt_op_address] <= rt_value_op;
    end
  end

  // Collision pulse and saturating counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_collision    <= 1'b0;
      collision_count <= '0;
    end else begin
      wr_collision <= collide;
      if (collide && collision_count != 16'hFFFF) collision_count <= collision_count + 16'd1;
    end
  end

  assign rd_addr[0] = ra_ep_address;
  assign rd_addr[1] = rb_ep_address;
  assign rd_addr[2] = rc_ep_address;
  assign rd_addr[3] = ra_op_address;
  assign rd_addr[4] = rb_op_address;
  assign rd_addr[5] = rc_op_address;

  for (genvar i = 0; i < NPORT; i++) begin : g_rd
    // Read mux: zero while clearing, else array with optional forwarding.
    always_comb begin
      rd_val[i] = '0;
      if (ready) begin
        rd_val[i] = mem[rd_addr[i]];
        if (FWD_EN) begin
          if (wr_op_go && rt_op_address == rd_addr[i])      rd_val[i] = rt_value_op;
          else if (wr_ep_go && rt_ep_address == rd_addr[i]) rd_val[i] = rt_value_ep;
        end
      end
    end
  end

  assign ra_ep_value = rd_val[0];
  assign rb_ep_value = rd_val[1];
  assign rc_ep_value = rd_val[2];
  assign ra_op_value = rd_val[3];
  assign rb_op_value = rd_val[4];
  assign rc_op_value = rd_val[5];

endmodule
